// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the CNN datapath stages.
package cnn_pkg;

  localparam int CNN_WORD_SIZE = 16;

  typedef logic signed [CNN_WORD_SIZE-1:0] word_t;

  function automatic word_t smax(word_t a, word_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic word_t relu(word_t x);
    return x[CNN_WORD_SIZE-1] ? word_t'(0) : x;
  endfunction

endpackage

// File: rtl/max_pool_channel.sv
// One channel of the max-pool window: holds the running maximum and
// presents the window result including the word currently on data_i.
module max_pool_channel
  import cnn_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     first_i,
  input  logic                     en_i,
  input  logic [CNN_WORD_SIZE-1:0] data_i,
  output logic [CNN_WORD_SIZE-1:0] cand_o
);

  word_t pool_r;

  // First word of a window replaces the stale maximum instead of comparing with it.
  assign cand_o = first_i ? data_i : smax(pool_r, word_t'(data_i));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pool_r <= '0;
    end else if (en_i) begin
      pool_r <= word_t'(cand_o);
    end
  end

endmodule

// File: rtl/max_pool_layer.sv
// Channel-parallel 1-D max-pool with optional ReLU and end-of-frame marking.
// Windows are cut at frame boundaries, so a short tail window closes early.
module max_pool_layer
  import cnn_pkg::*;
#(
  parameter int N_CHANNELS   = 256,
  parameter int WORD_SIZE    = CNN_WORD_SIZE,
  parameter int POOL_SIZE    = 2,
  parameter int FRAME_LENGTH = 60,
  parameter int RELU_EN      = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [N_CHANNELS*WORD_SIZE-1:0] data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [N_CHANNELS*WORD_SIZE-1:0] data_o,
  output logic                            last_o
);

  localparam int WIN_W = $clog2(POOL_SIZE + 1);
  localparam int FRM_W = $clog2(FRAME_LENGTH + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL_SIZE - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LENGTH - 1);

  logic [WIN_W-1:0]               win_cnt_r;
  logic [FRM_W-1:0]               frame_cnt_r;
  logic                           valid_r;
  logic                           last_r;
  logic [N_CHANNELS*WORD_SIZE-1:0] data_r;

  logic                 win_first;
  logic                 frame_end;
  logic                 closing_slot;
  logic                 hs_in;
  logic                 hs_out;
  logic                 close;
  logic [WORD_SIZE-1:0] cand [N_CHANNELS];

  assign win_first    = (win_cnt_r == '0);
  assign frame_end    = (frame_cnt_r == FRM_LAST);
  assign closing_slot = (win_cnt_r == WIN_LAST) | frame_end;

  // Only a closing input needs the output register free (or freeing this cycle).
  assign ready_o = ~closing_slot | ~valid_r | ready_i;
  assign hs_in   = valid_i & ready_o;
  assign hs_out  = valid_r & ready_i;
  assign close   = hs_in & closing_slot;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    max_pool_channel u_ch (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .first_i (win_first),
      .en_i    (hs_in),
      .data_i  (data_i[c*WORD_SIZE +: WORD_SIZE]),
      .cand_o  (cand[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      win_cnt_r   <= '0;
      frame_cnt_r <= '0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      data_r      <= '0;
    end else begin
      if (hs_in) begin
        win_cnt_r   <= closing_slot ? '0 : win_cnt_r + 1'b1;
        frame_cnt_r <= frame_end ? '0 : frame_cnt_r + 1'b1;
      end
      if (close) begin
        valid_r <= 1'b1;
        last_r  <= frame_end;
        for (int c = 0; c < N_CHANNELS; c++) begin
          data_r[c*WORD_SIZE +: WORD_SIZE] <= (RELU_EN != 0) ? relu(word_t'(cand[c])) : cand[c];
        end
      end else if (hs_out) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end
  end

  assign valid_o = valid_r;
  assign last_o  = last_r;
  assign data_o  = data_r;

endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer using four small configurations side by side.
module tb_max_pool_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // A: P=2 F=4 ReLU   B: P=2 F=4 no ReLU   C: P=2 F=5 ReLU   D: P=1 F=4 ReLU
  logic        rst_a, rst_o;
  logic        vi_a, vi_b, vi_c, vi_d;
  logic        ri_a, ri_b, ri_c, ri_d;
  logic        ro_a, ro_b, ro_c, ro_d;
  logic        vo_a, vo_b, vo_c, vo_d;
  logic        lo_a, lo_b, lo_c, lo_d;
  logic [31:0] di_a, di_b, di_c, di_d;
  logic [31:0] do_a, do_b, do_c, do_d;

  max_pool_layer #(.N_CHANNELS(2), .WORD_SIZE(16), .POOL_SIZE(2), .FRAME_LENGTH(4), .RELU_EN(1)) u_a (
    .clk_i(clk), .reset_i(rst_a), .valid_i(vi_a), .ready_o(ro_a), .data_i(di_a),
    .valid_o(vo_a), .ready_i(ri_a), .data_o(do_a), .last_o(lo_a));
  max_pool_layer #(.N_CHANNELS(2), .WORD_SIZE(16), .POOL_SIZE(2), .FRAME_LENGTH(4), .RELU_EN(0)) u_b (
    .clk_i(clk), .reset_i(rst_o), .valid_i(vi_b), .ready_o(ro_b), .data_i(di_b),
    .valid_o(vo_b), .ready_i(ri_b), .data_o(do_b), .last_o(lo_b));
  max_pool_layer #(.N_CHANNELS(2), .WORD_SIZE(16), .POOL_SIZE(2), .FRAME_LENGTH(5), .RELU_EN(1)) u_c (
    .clk_i(clk), .reset_i(rst_o), .valid_i(vi_c), .ready_o(ro_c), .data_i(di_c),
    .valid_o(vo_c), .ready_i(ri_c), .data_o(do_c), .last_o(lo_c));
  max_pool_layer #(.N_CHANNELS(2), .WORD_SIZE(16), .POOL_SIZE(1), .FRAME_LENGTH(4), .RELU_EN(1)) u_d (
    .clk_i(clk), .reset_i(rst_o), .valid_i(vi_d), .ready_o(ro_d), .data_i(di_d),
    .valid_o(vo_d), .ready_i(ri_d), .data_o(do_d), .last_o(lo_d));

  function automatic logic [31:0] pk(int c1, int c0);
    logic [31:0] a, b;
    a = c1;
    b = c0;
    return {a[15:0], b[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int d_c0 [4] = '{5, -3, 9, 2};
  int d_c1 [4] = '{1, 2, 3, 4};
  int d_e0 [4] = '{5, 0, 9, 2};

  initial begin
    rst_a = 1'b1; rst_o = 1'b1;
    vi_a = 0; vi_b = 0; vi_c = 0; vi_d = 0;
    ri_a = 1; ri_b = 1; ri_c = 1; ri_d = 1;
    di_a = '0; di_b = '0; di_c = '0; di_d = '0;
    tick(); tick();
    rst_a = 1'b0; rst_o = 1'b0;
    #1;
    chk("rst_valid", 32'(vo_a), 32'(0));
    chk("rst_last", 32'(lo_a), 32'(0));
    chk("rst_data", do_a, 32'h0);
    chk("rst_ready", 32'(ro_a), 32'(1));

    // Test 1: basic pooling with ReLU and channel packing
    vi_a = 1; di_a = pk(-1, 3);  tick();
    chk("t1_no_early_valid", 32'(vo_a), 32'(0));
    di_a = pk(-8, 7);            tick();
    chk("t1_out1_valid", 32'(vo_a), 32'(1));
    chk("t1_out1_data", do_a, pk(0, 7));
    chk("t1_out1_last", 32'(lo_a), 32'(0));
    di_a = pk(4, -5);            tick();
    chk("t1_drop_valid", 32'(vo_a), 32'(0));
    di_a = pk(6, -2);            tick();
    chk("t1_out2_valid", 32'(vo_a), 32'(1));
    chk("t1_out2_data", do_a, pk(6, 0));
    chk("t1_out2_last", 32'(lo_a), 32'(1));
    vi_a = 0;                    tick();
    chk("t1_idle_valid", 32'(vo_a), 32'(0));

    // Test 2: signed compare without ReLU
    vi_b = 1; di_b = pk(3, -5);  tick();
    di_b = pk(-4, -2);           tick();
    vi_b = 0;
    chk("t2_valid", 32'(vo_b), 32'(1));
    chk("t2_data", do_b, 32'h0003_FFFE);
    chk("t2_last", 32'(lo_b), 32'(0));

    // Test 3: odd frame length, tail window and restart
    vi_c = 1; di_c = pk(0, 1);   tick();
    chk("t3_in1_valid", 32'(vo_c), 32'(0));
    di_c = pk(0, 2);             tick();
    chk("t3_out1_data", do_c, pk(0, 2));
    chk("t3_out1_valid", 32'(vo_c), 32'(1));
    di_c = pk(0, 3);             tick();
    chk("t3_in3_valid", 32'(vo_c), 32'(0));
    di_c = pk(0, 4);             tick();
    chk("t3_out2_data", do_c, pk(0, 4));
    chk("t3_out2_last", 32'(lo_c), 32'(0));
    di_c = pk(0, 9);             tick();
    chk("t3_tail_valid", 32'(vo_c), 32'(1));
    chk("t3_tail_data", do_c, pk(0, 9));
    chk("t3_tail_last", 32'(lo_c), 32'(1));
    di_c = pk(0, 5);             tick();
    chk("t3_restart_valid", 32'(vo_c), 32'(0));
    di_c = pk(0, 1);             tick();
    chk("t3_restart_data", do_c, pk(0, 5));
    chk("t3_restart_last", 32'(lo_c), 32'(0));
    vi_c = 0;

    // Test 4: downstream stall on A
    vi_a = 1; di_a = pk(0, 3);   tick();
    di_a = pk(0, 7);             tick();
    chk("t4_first_data", do_a, pk(0, 7));
    ri_a = 0; di_a = pk(0, 1);   #1;
    chk("t4_nonclose_ready", 32'(ro_a), 32'(1));
    tick();
    di_a = pk(0, 2);             #1;
    chk("t4_close_ready", 32'(ro_a), 32'(0));
    tick();
    chk("t4_hold_valid", 32'(vo_a), 32'(1));
    chk("t4_hold_data", do_a, pk(0, 7));
    chk("t4_hold_last", 32'(lo_a), 32'(0));
    chk("t4_still_blocked", 32'(ro_a), 32'(0));
    ri_a = 1;                    #1;
    chk("t4_release_ready", 32'(ro_a), 32'(1));
    tick();
    chk("t4_next_valid", 32'(vo_a), 32'(1));
    chk("t4_next_data", do_a, pk(0, 2));
    chk("t4_next_last", 32'(lo_a), 32'(1));
    vi_a = 0;                    tick();
    chk("t4_drain_valid", 32'(vo_a), 32'(0));

    // Test 5: POOL_SIZE=1 streaming pass-through
    vi_d = 1;
    for (int i = 0; i < 4; i++) begin
      di_d = pk(d_c1[i], d_c0[i]);
      tick();
      chk("t5_valid", 32'(vo_d), 32'(1));
      chk("t5_data", do_d, pk(d_c1[i], d_e0[i]));
      chk("t5_last", 32'(lo_d), (i == 3) ? 32'(1) : 32'(0));
    end
    vi_d = 0;                    tick();
    chk("t5_idle_valid", 32'(vo_d), 32'(0));

    // Test 6: reset mid-window discards the partial window
    vi_a = 1; di_a = pk(0, 8);   tick();
    vi_a = 0; rst_a = 1;         tick();
    rst_a = 0;
    chk("t6_rst_valid", 32'(vo_a), 32'(0));
    chk("t6_rst_last", 32'(lo_a), 32'(0));
    chk("t6_rst_data", do_a, 32'h0);
    vi_a = 1; di_a = pk(0, 4);   tick();
    chk("t6_new_window", 32'(vo_a), 32'(0));
    di_a = pk(0, 1);             tick();
    vi_a = 0;
    chk("t6_out_valid", 32'(vo_a), 32'(1));
    chk("t6_out_data", do_a, pk(0, 4));
    chk("t6_out_last", 32'(lo_a), 32'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
